uncached_wbuf: RTL and testbench

Posted-write buffer and single-outstanding bridge for uncached (kseg1) data accesses. It sits directly downstream of the MMU: the data port drives it whenever the MMU flags an access as uncacheable. It accepts physical addresses only. Uncached stores are queued and acknowledged immediately so the pipeline does not stall on MMIO writes. Uncached loads wait until every queued store has completed on the memory side, which preserves strict program order.

---
 rtl/uncached_wbuf_pkg.sv | 25 ++
 rtl/uncached_wbuf_fifo.sv | 55 +++++
 rtl/uncached_wbuf.sv | 169 ++++++++++++++++
 tb/tb_uncached_wbuf.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uncached_wbuf_pkg.sv
// rtl/uncached_wbuf_pkg.sv - shared types for the uncached write buffer
// Contents: access size encoding, bridge FSM states, store queue entry.
package uncached_wbuf_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        size_e       size;
        logic [31:0] wdata;
    } sq_entry_t;

endpackage

// File: rtl/uncached_wbuf_fifo.sv
// rtl/uncached_wbuf_fifo.sv - store queue FIFO (module ucwb_fifo)
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write an entry (ignored when full)
//   pop             retire the head entry (ignored when empty)
//   full, empty     occupancy flags, from current pointers only
//   head            oldest entry
module ucwb_fifo
    import uncached_wbuf_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = sq_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uncached_wbuf.sv
// rtl/uncached_wbuf.sv - posted uncached store buffer and single-outstanding load bridge
// Optional feature macro: UCWB_STATS_EN (adds stat_stall_cnt).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_req/wr/size/addr/wdata     uncached access request from the data port
//   cpu_addr_ok                    request accepted (combinational)
//   cpu_data_ok, cpu_rdata         completion pulse and load data (registered)
//   mem_req/wr/size/addr/wdata     memory-side request (registered)
//   mem_addr_ok, mem_data_ok       memory request accept / completion
//   mem_rdata                      read data, valid with mem_data_ok
//   stat_stall_cnt                 saturating refused-request cycle count
module uncached_wbuf
    import uncached_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
`ifdef UCWB_STATS_EN
    ,
    output logic [31:0] stat_stall_cnt
`endif
);

    state_e      state;
    state_e      state_nxt;
    sq_entry_t   push_entry;
    sq_entry_t   head;
    logic        full;
    logic        empty;
    logic        ld_busy;
    logic        st_accept;
    logic        ld_accept;
    logic        fifo_pop;
    logic        mem_req_d;
    logic        mem_wr_d;
    logic [1:0]  mem_size_d;
    logic [31:0] mem_addr_d;
    logic [31:0] mem_wdata_d;
    logic        cpu_data_ok_d;

    // Stores are refused while a load is in flight so acks stay in request order.
    assign st_accept   = cpu_req & cpu_wr & ~full & ~ld_busy;
    // A load waits for every posted store; an empty queue means none is outstanding.
    assign ld_accept   = cpu_req & ~cpu_wr & empty & (state == IDLE) & ~ld_busy;
    assign cpu_addr_ok = st_accept | ld_accept;

    assign push_entry = '{addr: cpu_addr, size: size_e'(cpu_size), wdata: cpu_wdata};

    ucwb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (sq_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (st_accept),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_accept) begin
                    state_nxt = RD_ADDR;
                end else if (!empty) begin
                    state_nxt = WR_ADDR;
                end
            end
            WR_ADDR: if (mem_addr_ok) state_nxt = WR_RESP;
            WR_RESP: if (mem_data_ok) state_nxt = IDLE;
            RD_ADDR: if (mem_addr_ok) state_nxt = RD_RESP;
            RD_RESP: if (mem_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_* are loaded only when entering an address phase and held otherwise,
    // which keeps them stable until mem_addr_ok. The mem_addr/mem_size registers
    // double as the load latch.
    always_comb begin
        mem_req_d   = (state_nxt == WR_ADDR) || (state_nxt == RD_ADDR);
        mem_wr_d    = mem_wr;
        mem_size_d  = mem_size;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if ((state == IDLE) && (state_nxt == WR_ADDR)) begin
            mem_wr_d    = 1'b1;
            mem_size_d  = head.size;
            mem_addr_d  = head.addr;
            mem_wdata_d = head.wdata;
        end else if (ld_accept) begin
            mem_wr_d    = 1'b0;
            mem_size_d  = cpu_size;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = '0;
        end
        fifo_pop      = (state == WR_RESP) && mem_data_ok;
        cpu_data_ok_d = st_accept || ((state == RD_RESP) && mem_data_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_size    <= 2'd0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_data_ok <= 1'b0;
            cpu_rdata   <= '0;
            ld_busy     <= 1'b0;
        end else begin
            mem_req     <= mem_req_d;
            mem_wr      <= mem_wr_d;
            mem_size    <= mem_size_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            cpu_data_ok <= cpu_data_ok_d;
            if ((state == RD_RESP) && mem_data_ok) begin
                cpu_rdata <= mem_rdata;
            end
            // While ld_busy is set the only possible ack is the load's own.
            if (ld_accept) begin
                ld_busy <= 1'b1;
            end else if (cpu_data_ok) begin
                ld_busy <= 1'b0;
            end
        end
    end

`ifdef UCWB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stall_cnt <= '0;
        end else if (cpu_req && !cpu_addr_ok && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uncached_wbuf.sv
// tb/tb_uncached_wbuf.sv - scoreboard bench for uncached_wbuf
module tb_uncached_wbuf;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_addr_ok;
    logic        cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
`ifdef UCWB_STATS_EN
    logic [31:0] stat_stall_cnt;
`endif

    uncached_wbuf #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_wr      (cpu_wr),
        .cpu_size    (cpu_size),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_addr_ok (cpu_addr_ok),
        .cpu_data_ok (cpu_data_ok),
        .cpu_rdata   (cpu_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
`ifdef UCWB_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
    } cpu_exp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          stall_ref = 0;
    logic        resp_en = 1'b1;
    logic        pend = 1'b0;
    logic [31:0] rd_value = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata);
        cpu_exp_t c;
        mem_exp_t m;
        c.is_load = !wr;
        c.rdata   = rdata;
        m.wr      = wr;
        m.size    = size;
        m.addr    = addr;
        m.wdata   = wr ? wdata : 32'd0;
        cpu_q.push_back(c);
        mem_q.push_back(m);
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, output int waits);
        bit ok;
        ok = 0;
        waits = 0;
        cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cpu_addr_ok) begin
                ok = 1;
                push_exp(wr, size, addr, wdata, rdata);
            end else begin
                waits++;
                stall_ref++;
            end
            step();
        end
        cpu_req = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL issue_timeout: request at addr %0h never accepted", addr);
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300 && (cpu_q.size() != 0 || mem_q.size() != 0); i++) step();
        if (i == 300) begin
            n_total++;
            $display("FAIL drain_timeout: cpu_q=%0d mem_q=%0d outstanding", cpu_q.size(), mem_q.size());
        end
        repeat (2) step();
    endtask

    // Memory responder: completes each accepted request one cycle later.
    initial begin
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                mem_data_ok = 1'b0;
            end else begin
                if (mem_data_ok) begin
                    mem_data_ok = 1'b0;
                    pend = 1'b0;
                end else if (pend && resp_en) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = rd_value;
                end
                if (mem_req && mem_addr_ok) pend = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        cpu_exp_t c;
        mem_exp_t m;
        forever begin
            @(negedge clk);
            if (!rst && cpu_data_ok) begin
                if (cpu_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_cpu_data_ok: got 1 expected 0");
                end else begin
                    c = cpu_q.pop_front();
                    if (c.is_load) check("cpu_rdata", cpu_rdata, c.rdata);
                end
            end
            if (!rst && mem_req && mem_addr_ok) begin
                if (mem_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_mem_req: addr %0h", mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_txn", {mem_wr, mem_size, mem_addr, mem_wr ? mem_wdata : 32'd0},
                          {m.wr, m.size, m.addr, m.wdata});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0; cpu_addr = '0; cpu_wdata = '0;
        mem_addr_ok = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_cpu_data_ok", cpu_data_ok, 1'b0);
        check("rst_cpu_addr_ok", cpu_addr_ok, 1'b0);
        check("rst_outputs", {mem_wr, mem_size, mem_addr, mem_wdata, cpu_rdata}, 99'd0);
`ifdef UCWB_STATS_EN
        check("rst_stat", stat_stall_cnt, 32'd0);
`endif
        step();
        rst = 1'b0;
        mem_addr_ok = 1'b1;

        // Reset while in WR_RESP with three stores queued.
        resp_en = 1'b0;
        issue(1'b1, 2'd2, 32'h1F00_0000, 32'h0000_0001, 32'd0, w);
        issue(1'b1, 2'd2, 32'h1F00_0004, 32'h0000_0002, 32'd0, w);
        check("rstt_mem_req_before", mem_req, 1'b1);
        issue(1'b1, 2'd2, 32'h1F00_0008, 32'h0000_0003, 32'd0, w);
        check("rstt_ack_pending", cpu_data_ok, 1'b1);
        rst = 1'b1;
        cpu_q.delete();
        mem_q.delete();
        stall_ref = 0;
        #1;
        check("rstt_mem_req_drop", mem_req, 1'b0);
        check("rstt_ack_drop", cpu_data_ok, 1'b0);
        repeat (2) step();
        resp_en = 1'b1;
        rst = 1'b0;
`ifdef UCWB_STATS_EN
        check("rstt_stat", stat_stall_cnt, 32'd0);
`endif
        rd_value = 32'h0BAD_F00D;
        issue(1'b0, 2'd2, 32'h1F00_0100, 32'd0, 32'h0BAD_F00D, w);
        check("rstt_load_immediate", w, 0);
        wait_idle();

        // Single store with same-cycle memory acks.
        issue(1'b1, 2'd2, 32'h1FAF_0000, 32'hDEAD_BEEF, 32'd0, w);
        @(negedge clk);
        check("st1_data_ok_t1", cpu_data_ok, 1'b1);
        check("st1_mem_req_t1", mem_req, 1'b0);
        @(negedge clk);
        check("st1_mem_req_t2", mem_req, 1'b1);
        check("st1_mem_fields", {mem_wr, mem_size, mem_addr, mem_wdata},
              {1'b1, 2'd2, 32'h1FAF_0000, 32'hDEAD_BEEF});
        @(negedge clk);
        check("st1_mem_req_resp", mem_req, 1'b0);
        step();
        rd_value = 32'hCAFE_0001;
        issue(1'b0, 2'd2, 32'h1FAF_0004, 32'd0, 32'hCAFE_0001, w);
        check("st1_queue_empty", w, 0);
        wait_idle();

        // Fill the queue with memory stalled, then drain in order.
        mem_addr_ok = 1'b0;
        issue(1'b1, 2'd0, 32'h1F10_0001, 32'h0000_AA00, 32'd0, w);
        issue(1'b1, 2'd1, 32'h1F10_0002, 32'hBBBB_0000, 32'd0, w);
        issue(1'b1, 2'd2, 32'h1F10_0004, 32'h1111_2222, 32'd0, w);
        issue(1'b1, 2'd2, 32'h1F10_0008, 32'h3333_4444, 32'd0, w);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd2;
        cpu_addr = 32'h1F10_000C; cpu_wdata = 32'h5555_6666;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_refuse", cpu_addr_ok, 1'b0);
            stall_ref++;
            step();
        end
        mem_addr_ok = 1'b1;
        issue(1'b1, 2'd2, 32'h1F10_000C, 32'h5555_6666, 32'd0, w);
        check("full_accept_after_pop", w, 2);
        wait_idle();
`ifdef UCWB_STATS_EN
        check("stat_after_full", stat_stall_cnt, stall_ref);
`endif

        // Store followed by a load: load waits for the write to complete.
        issue(1'b1, 2'd2, 32'h1FD0_F000, 32'hA0A0_B0B0, 32'd0, w);
        rd_value = 32'h1234_5678;
        issue(1'b0, 2'd2, 32'h1FD0_F004, 32'd0, 32'h1234_5678, w);
        check("ld_waits_for_store", w, 3);
        @(negedge clk);
        check("ld_mem_req_t1", {mem_req, mem_wr, mem_size, mem_addr},
              {1'b1, 1'b0, 2'd2, 32'h1FD0_F004});
        @(negedge clk);
        check("ld_no_early_ack", cpu_data_ok, 1'b0);
        @(negedge clk);
        check("ld_ack_r1", cpu_data_ok, 1'b1);
        check("ld_rdata_r1", cpu_rdata, 32'h1234_5678);
        wait_idle();

        // Store behind an outstanding load.
        resp_en = 1'b0;
        rd_value = 32'hA5A5_5A5A;
        issue(1'b0, 2'd2, 32'h1FD0_0010, 32'd0, 32'hA5A5_5A5A, w);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd2;
        cpu_addr = 32'h1FD0_0020; cpu_wdata = 32'h1122_3344;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_behind_ld_refuse", cpu_addr_ok, 1'b0);
            stall_ref++;
            step();
        end
        resp_en = 1'b1;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (cpu_data_ok) begin
                    seen = 1;
                    check("st_refused_at_ld_ack", cpu_addr_ok, 1'b0);
                end
                if (!cpu_addr_ok) stall_ref++;
                step();
            end
            if (!seen) begin
                n_total++;
                $display("FAIL ld_ack_timeout: load cpu_data_ok never seen");
            end
        end
        @(negedge clk);
        check("st_accept_after_ld_ack", cpu_addr_ok, 1'b1);
        if (cpu_addr_ok) push_exp(1'b1, 2'd2, 32'h1FD0_0020, 32'h1122_3344, 32'd0);
        else stall_ref++;
        step();
        cpu_req = 1'b0;
        wait_idle();

        check("final_cpu_q_empty", cpu_q.size(), 0);
        check("final_mem_q_empty", mem_q.size(), 0);
`ifdef UCWB_STATS_EN
        check("final_stat", stat_stall_cnt, stall_ref);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
